// File: rtl/core_lsu.sv
// core_lsu: RV32 load/store unit. It sizes and aligns core requests and drives the wb_master cmd/busy interface.
// Optional macro LSU_MISALIGN_SPLIT_EN splits word-crossing accesses into two bus transactions.

package core_lsu_pkg;
  typedef enum logic [1:0] {
    WISHBONE_CMD_NONE  = 2'd0,
    WISHBONE_CMD_LOAD  = 2'd1,
    WISHBONE_CMD_STORE = 2'd2
  } wb_command_t;

  typedef enum logic [2:0] {
    LSU_IDLE   = 3'd0,
    LSU_ISSUE  = 3'd1,
    LSU_WAIT   = 3'd2,
    LSU_RESP   = 3'd3,
    LSU_ISSUE2 = 3'd4,
    LSU_WAIT2  = 3'd5
  } lsu_state_t;
endpackage

module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    req_valid_in,
  output logic                    req_ready_out,
  input  logic                    req_store_in,
  input  logic [2:0]              req_funct3_in,
  input  logic [ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [DATA_WIDTH-1:0]   req_wdata_in,
  output logic                    resp_valid_out,
  output logic [DATA_WIDTH-1:0]   resp_rdata_out,
  output logic                    resp_fault_out,
  output wb_command_t             bus_cmd_out,
  input  logic                    bus_busy_in,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_in,
  output logic [DATA_WIDTH-1:0]   bus_wdata_out,
  output logic [DATA_WIDTH/8-1:0] bus_wmask_out,
  output logic [ADDR_WIDTH-1:0]   bus_addr_out,
  output lsu_state_t              dbg_state_out
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFS = $clog2(NB);
  localparam logic [NB-1:0] ONE_NB = 1;

  // Request handshake: a request transfers on the rising edge where req_valid_in && req_ready_out;
  // ready is high only in IDLE, and a request presented in any other state is ignored, not queued.
  lsu_state_t r_state, w_next;

  logic                  r_store, r_unsigned, r_fault;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_lo;

  logic w_accept, w_size_ill, w_store_ill, w_illegal;

  assign w_accept    = req_valid_in && req_ready_out;
  assign w_size_ill  = (req_funct3_in[1:0] == 2'b11) && (DATA_WIDTH == 32);
  assign w_store_ill = req_store_in && req_funct3_in[2];

`ifdef LSU_MISALIGN_SPLIT_EN
  logic                  r_cross;
  logic [DATA_WIDTH-1:0] r_hi;
  logic                  w_cross;
  assign w_cross   = (32'(req_addr_in[OFS-1:0]) + (32'd1 << req_funct3_in[1:0])) > 32'(NB);
  assign w_illegal = w_size_ill || w_store_ill;
`else
  logic [2:0] w_req_amask;
  always_comb begin
    case (req_funct3_in[1:0])
      2'b00:   w_req_amask = 3'b000;
      2'b01:   w_req_amask = 3'b001;
      2'b10:   w_req_amask = 3'b011;
      default: w_req_amask = 3'b111;
    endcase
  end
  assign w_illegal = w_size_ill || w_store_ill || (|(req_addr_in[2:0] & w_req_amask));
`endif

  // Lane geometry of the latched request.
  logic [OFS-1:0]        w_ofs;
  logic [OFS+2:0]        w_bit_ofs;
  logic [3:0]            w_nbytes;
  logic [NB-1:0]         w_size_bytes;
  logic [ADDR_WIDTH-1:0] w_word_addr;

  assign w_ofs        = r_addr[OFS-1:0];
  assign w_bit_ofs    = {w_ofs, 3'b000};
  assign w_nbytes     = 4'd1 << r_size;
  assign w_size_bytes = (ONE_NB << w_nbytes) - ONE_NB;
  assign w_word_addr  = {r_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};

  logic [NB-1:0]         w_mask_lo, w_mask_hi;
  logic [DATA_WIDTH-1:0] w_wdata_lo, w_wdata_hi, w_load_sh;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [2*NB-1:0]         w_mask2;
  logic [2*DATA_WIDTH-1:0] w_wdata2, w_load2;
  assign w_mask2    = {{NB{1'b0}}, w_size_bytes} << w_ofs;
  assign w_wdata2   = {{DATA_WIDTH{1'b0}}, r_wdata} << w_bit_ofs;
  assign w_load2    = {r_hi, r_lo} >> w_bit_ofs;
  assign w_mask_lo  = w_mask2[NB-1:0];
  assign w_mask_hi  = w_mask2[2*NB-1:NB];
  assign w_wdata_lo = w_wdata2[DATA_WIDTH-1:0];
  assign w_wdata_hi = w_wdata2[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_load_sh  = w_load2[DATA_WIDTH-1:0];
`else
  assign w_mask_lo  = w_size_bytes << w_ofs;
  assign w_mask_hi  = '0;
  assign w_wdata_lo = r_wdata << w_bit_ofs;
  assign w_wdata_hi = '0;
  assign w_load_sh  = r_lo >> w_bit_ofs;
`endif

  // Load extension: keep the low n bytes, fill the rest with the sign bit unless unsigned.
  logic [DATA_WIDTH-1:0] w_keep, w_ext;
  logic                  w_sign;

  always_comb begin
    w_keep = '0;
    for (int i = 0; i < NB; i++) begin
      w_keep[8*i +: 8] = {8{w_size_bytes[i]}};
    end
  end

  always_comb begin
    case (r_size)
      2'b00:   w_sign = w_load_sh[7];
      2'b01:   w_sign = w_load_sh[15];
      2'b10:   w_sign = w_load_sh[31];
      default: w_sign = w_load_sh[DATA_WIDTH-1];
    endcase
  end

  assign w_ext = (w_load_sh & w_keep) | ({DATA_WIDTH{w_sign && !r_unsigned}} & ~w_keep);

  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE:   if (w_accept) w_next = w_illegal ? LSU_RESP : LSU_ISSUE;
      LSU_ISSUE:  w_next = LSU_WAIT;
`ifdef LSU_MISALIGN_SPLIT_EN
      LSU_WAIT:   if (!bus_busy_in) w_next = r_cross ? LSU_ISSUE2 : LSU_RESP;
`else
      LSU_WAIT:   if (!bus_busy_in) w_next = LSU_RESP;
`endif
      LSU_ISSUE2: w_next = LSU_WAIT2;
      LSU_WAIT2:  if (!bus_busy_in) w_next = LSU_RESP;
      LSU_RESP:   w_next = LSU_IDLE;
      default:    w_next = LSU_IDLE;
    endcase
  end

  logic w_first, w_second;
  assign w_first  = (r_state == LSU_ISSUE)  || (r_state == LSU_WAIT);
  assign w_second = (r_state == LSU_ISSUE2) || (r_state == LSU_WAIT2);

  always_comb begin
    bus_cmd_out   = WISHBONE_CMD_NONE;
    bus_addr_out  = '0;
    bus_wdata_out = '0;
    bus_wmask_out = '0;
    if ((r_state == LSU_ISSUE) || (r_state == LSU_ISSUE2)) begin
      bus_cmd_out = r_store ? WISHBONE_CMD_STORE : WISHBONE_CMD_LOAD;
    end
    if (w_first) begin
      bus_addr_out  = w_word_addr;
      bus_wdata_out = w_wdata_lo;
      bus_wmask_out = r_store ? w_mask_lo : '0;
    end else if (w_second) begin
      bus_addr_out  = w_word_addr + ADDR_WIDTH'(NB);
      bus_wdata_out = w_wdata_hi;
      bus_wmask_out = r_store ? w_mask_hi : '0;
    end
  end

  assign req_ready_out  = (r_state == LSU_IDLE);
  assign resp_valid_out = (r_state == LSU_RESP);
  assign resp_fault_out = (r_state == LSU_RESP) && r_fault;
  assign resp_rdata_out = ((r_state == LSU_RESP) && !r_fault && !r_store) ? w_ext : '0;
  assign dbg_state_out  = r_state;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state    <= LSU_IDLE;
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_fault    <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_lo       <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_cross    <= 1'b0;
      r_hi       <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_store    <= req_store_in;
        r_unsigned <= req_funct3_in[2];
        r_size     <= req_funct3_in[1:0];
        r_addr     <= req_addr_in;
        r_wdata    <= req_wdata_in;
        r_fault    <= w_illegal;
`ifdef LSU_MISALIGN_SPLIT_EN
        r_cross    <= w_cross;
`endif
      end
      if ((r_state == LSU_WAIT) && !bus_busy_in) r_lo <= bus_rdata_in;
`ifdef LSU_MISALIGN_SPLIT_EN
      if ((r_state == LSU_WAIT2) && !bus_busy_in) r_hi <= bus_rdata_in;
`endif
    end
  end

endmodule

// File: tb/tb_core_lsu.sv
// Testbench for core_lsu: vector table plus hand sequences, wb_master model busy for 2 cycles,
// response scoreboard fed at request time and drained on resp_valid_out.

module tb_core_lsu;
  import core_lsu_pkg::*;

  localparam int DW          = 32;
  localparam int AW          = 32;
  localparam int NB          = DW / 8;
  localparam int BUSY_CYCLES = 2;
  localparam int W           = DW + 1;

  logic              clk           = 1'b0;
  logic              reset_in      = 1'b1;
  logic              req_valid_in  = 1'b0;
  logic              req_store_in  = 1'b0;
  logic [2:0]        req_funct3_in = '0;
  logic [AW-1:0]     req_addr_in   = '0;
  logic [DW-1:0]     req_wdata_in  = '0;
  logic              req_ready_out;
  logic              resp_valid_out;
  logic [DW-1:0]     resp_rdata_out;
  logic              resp_fault_out;
  wb_command_t       bus_cmd_out;
  logic              bus_busy_in   = 1'b0;
  logic [DW-1:0]     bus_rdata_in  = '0;
  logic [DW-1:0]     bus_wdata_out;
  logic [NB-1:0]     bus_wmask_out;
  logic [AW-1:0]     bus_addr_out;
  lsu_state_t        dbg_state_out;

  core_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_in         (clk),
    .reset_in       (reset_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_store_in   (req_store_in),
    .req_funct3_in  (req_funct3_in),
    .req_addr_in    (req_addr_in),
    .req_wdata_in   (req_wdata_in),
    .resp_valid_out (resp_valid_out),
    .resp_rdata_out (resp_rdata_out),
    .resp_fault_out (resp_fault_out),
    .bus_cmd_out    (bus_cmd_out),
    .bus_busy_in    (bus_busy_in),
    .bus_rdata_in   (bus_rdata_in),
    .bus_wdata_out  (bus_wdata_out),
    .bus_wmask_out  (bus_wmask_out),
    .bus_addr_out   (bus_addr_out),
    .dbg_state_out  (dbg_state_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- wb_master model ----------------
  logic [31:0] mem [logic [31:0]];
  int          bus_cmds = 0;
  int          busy_cnt = 0;
  logic [31:0] st_word;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (reset_in) begin
      bus_busy_in <= 1'b0;
      busy_cnt    <= 0;
    end else if (bus_cmd_out != WISHBONE_CMD_NONE) begin
      bus_cmds     <= bus_cmds + 1;
      bus_busy_in  <= 1'b1;
      busy_cnt     <= BUSY_CYCLES - 1;
      bus_rdata_in <= rd(bus_addr_out);
      if (bus_cmd_out == WISHBONE_CMD_STORE) begin
        st_word = rd(bus_addr_out);
        for (int i = 0; i < NB; i++)
          if (bus_wmask_out[i]) st_word[8*i +: 8] = bus_wdata_out[8*i +: 8];
        mem[bus_addr_out] = st_word;
      end
    end else if (bus_busy_in) begin
      if (busy_cnt == 0) bus_busy_in <= 1'b0;
      else               busy_cnt    <= busy_cnt - 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!reset_in && resp_valid_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL resp_unexpected: resp_valid=1 fault=%0b rdata=0x%0h, expected no response",
                 resp_fault_out, resp_rdata_out);
      end else begin
        check("resp_fault_rdata", 64'({resp_fault_out, resp_rdata_out}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        init;
    logic [31:0] lo_init;
    logic [31:0] hi_init;
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] bus_addr;
    logic [3:0]  wmask;
    logic [31:0] bus_wdata;
    int          ncmd;
  } vec_t;

  function automatic vec_t mk(input string name, input logic store, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic init,
                              input logic [31:0] lo_init, input logic [31:0] hi_init,
                              input logic fault, input logic [31:0] rdata, input logic [31:0] bus_addr,
                              input logic [3:0] wmask, input logic [31:0] bus_wdata, input int ncmd);
    vec_t v;
    v.name = name; v.store = store; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.init = init; v.lo_init = lo_init; v.hi_init = hi_init; v.fault = fault; v.rdata = rdata;
    v.bus_addr = bus_addr; v.wmask = wmask; v.bus_wdata = bus_wdata; v.ncmd = ncmd;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v);
    int          guard;
    longint      t_acc;
    int          cmds0;
    logic [31:0] word;
    if (v.init) begin
      word = {v.addr[31:2], 2'b00};
      mem[word]     = v.lo_init;
      mem[word + 4] = v.hi_init;
    end
    @(negedge clk);
    req_store_in  = v.store;
    req_funct3_in = v.f3;
    req_addr_in   = v.addr;
    req_wdata_in  = v.wdata;
    req_valid_in  = 1'b1;
    guard = 0;
    while (!req_ready_out && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("%s_ready", v.name), 64'(req_ready_out), 64'd1);
    cmds0 = bus_cmds;
    exp_q.push_back({v.fault, v.rdata});
    @(negedge clk);
    req_valid_in = 1'b0;
    t_acc = cyc;
    if (v.fault) begin
      check($sformatf("%s_fault_t1", v.name), 64'(resp_valid_out), 64'd1);
      check($sformatf("%s_cmd_none", v.name), 64'(bus_cmd_out), 64'(WISHBONE_CMD_NONE));
    end else begin
      check($sformatf("%s_cmd", v.name), 64'(bus_cmd_out),
            64'(v.store ? WISHBONE_CMD_STORE : WISHBONE_CMD_LOAD));
      check($sformatf("%s_bus_addr", v.name), 64'(bus_addr_out), 64'(v.bus_addr));
      check($sformatf("%s_wmask", v.name), 64'(bus_wmask_out), 64'(v.wmask));
      if (v.store) check($sformatf("%s_wdata", v.name), 64'(bus_wdata_out), 64'(v.bus_wdata));
    end
    guard = 0;
    while (!resp_valid_out && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("%s_latency", v.name), 64'(cyc - t_acc), 64'(v.fault ? 0 : 4 * v.ncmd));
    @(negedge clk);
    check($sformatf("%s_resp_pulse", v.name), 64'(resp_valid_out), 64'd0);
    check($sformatf("%s_bus_cmds", v.name), 64'(bus_cmds - cmds0), 64'(v.ncmd));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  initial begin
    vec_t   vecs[$];
    int     guard;
    int     pulses;
    longint t_acc;

    vecs.push_back(mk("lw_100",   0, 3'b010, 32'h100, 32'h0,        1, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF, 32'h100, 4'h0, 32'h0,        1));
    vecs.push_back(mk("lb_103",   0, 3'b000, 32'h103, 32'h0,        1, 32'h80FFFFFF, 32'h0, 0, 32'hFFFFFF80, 32'h100, 4'h0, 32'h0,        1));
    vecs.push_back(mk("lbu_103",  0, 3'b100, 32'h103, 32'h0,        1, 32'h80FFFFFF, 32'h0, 0, 32'h00000080, 32'h100, 4'h0, 32'h0,        1));
    vecs.push_back(mk("lh_102",   0, 3'b001, 32'h102, 32'h0,        1, 32'h80011234, 32'h0, 0, 32'hFFFF8001, 32'h100, 4'h0, 32'h0,        1));
    vecs.push_back(mk("lhu_102",  0, 3'b101, 32'h102, 32'h0,        1, 32'h80011234, 32'h0, 0, 32'h00008001, 32'h100, 4'h0, 32'h0,        1));
    vecs.push_back(mk("sh_202",   1, 3'b001, 32'h202, 32'h1234ABCD, 0, 32'h0,        32'h0, 0, 32'h0,        32'h200, 4'hC, 32'hABCD0000, 1));
    vecs.push_back(mk("lb_202",   0, 3'b000, 32'h202, 32'h0,        0, 32'h0,        32'h0, 0, 32'hFFFFFFCD, 32'h200, 4'h0, 32'h0,        1));
    vecs.push_back(mk("sb_205",   1, 3'b000, 32'h205, 32'h123456A5, 0, 32'h0,        32'h0, 0, 32'h0,        32'h204, 4'h2, 32'h3456A500, 1));
    vecs.push_back(mk("lbu_205",  0, 3'b100, 32'h205, 32'h0,        0, 32'h0,        32'h0, 0, 32'h000000A5, 32'h204, 4'h0, 32'h0,        1));
    vecs.push_back(mk("sw_300",   1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h0,        32'h0, 0, 32'h0,        32'h300, 4'hF, 32'hCAFEF00D, 1));
    vecs.push_back(mk("lw_300",   0, 3'b010, 32'h300, 32'h0,        0, 32'h0,        32'h0, 0, 32'hCAFEF00D, 32'h300, 4'h0, 32'h0,        1));
    vecs.push_back(mk("ld_f3_011",0, 3'b011, 32'h100, 32'h0,        0, 32'h0,        32'h0, 1, 32'h0,        32'h0,   4'h0, 32'h0,        0));
    vecs.push_back(mk("st_f3_100",1, 3'b100, 32'h200, 32'h55,       0, 32'h0,        32'h0, 1, 32'h0,        32'h0,   4'h0, 32'h0,        0));
    vecs.push_back(mk("st_f3_110",1, 3'b110, 32'h300, 32'h55,       0, 32'h0,        32'h0, 1, 32'h0,        32'h0,   4'h0, 32'h0,        0));
    vecs.push_back(mk("sd_f3_011",1, 3'b011, 32'h300, 32'h55,       0, 32'h0,        32'h0, 1, 32'h0,        32'h0,   4'h0, 32'h0,        0));
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back(mk("lw_101",   0, 3'b010, 32'h101, 32'h0,        1, 32'h44332211, 32'h88776655, 0, 32'h55443322, 32'h100, 4'h0, 32'h0,  2));
    vecs.push_back(mk("lh_103",   0, 3'b001, 32'h103, 32'h0,        1, 32'h44332211, 32'h88776655, 0, 32'h00005544, 32'h100, 4'h0, 32'h0,  2));
    vecs.push_back(mk("lh_101",   0, 3'b001, 32'h101, 32'h0,        1, 32'h44332211, 32'h88776655, 0, 32'h00003322, 32'h100, 4'h0, 32'h0,  1));
    vecs.push_back(mk("sw_302",   1, 3'b010, 32'h302, 32'hAABBCCDD, 0, 32'h0,        32'h0,        0, 32'h0,        32'h300, 4'hC, 32'hCCDD0000, 2));
`else
    vecs.push_back(mk("lw_101",   0, 3'b010, 32'h101, 32'h0,        1, 32'h44332211, 32'h88776655, 1, 32'h0, 32'h0, 4'h0, 32'h0, 0));
    vecs.push_back(mk("lh_103",   0, 3'b001, 32'h103, 32'h0,        1, 32'h44332211, 32'h88776655, 1, 32'h0, 32'h0, 4'h0, 32'h0, 0));
    vecs.push_back(mk("lh_101",   0, 3'b001, 32'h101, 32'h0,        1, 32'h44332211, 32'h88776655, 1, 32'h0, 32'h0, 4'h0, 32'h0, 0));
    vecs.push_back(mk("sw_302",   1, 3'b010, 32'h302, 32'hAABBCCDD, 0, 32'h0,        32'h0,        1, 32'h0, 32'h0, 4'h0, 32'h0, 0));
`endif

    // Reset state, sampled while reset is still asserted and again after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",      64'(req_ready_out),  64'd1);
    check("rst_resp_valid", 64'(resp_valid_out), 64'd0);
    check("rst_rdata",      64'(resp_rdata_out), 64'd0);
    check("rst_fault",      64'(resp_fault_out), 64'd0);
    check("rst_cmd",        64'(bus_cmd_out),    64'(WISHBONE_CMD_NONE));
    check("rst_bus_addr",   64'(bus_addr_out),   64'd0);
    check("rst_bus_wdata",  64'(bus_wdata_out),  64'd0);
    check("rst_bus_wmask",  64'(bus_wmask_out),  64'd0);
    reset_in = 1'b0;
    @(negedge clk);
    check("idle_state", 64'(dbg_state_out), 64'(LSU_IDLE));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset pulsed in WAIT abandons the access without a response.
    mem[32'h100] = 32'hDEADBEEF;
    @(negedge clk);
    req_store_in = 1'b0; req_funct3_in = 3'b010; req_addr_in = 32'h100; req_valid_in = 1'b1;
    check("mid_rst_ready", 64'(req_ready_out), 64'd1);
    @(negedge clk);
    req_valid_in = 1'b0;
    check("mid_rst_issue_cmd", 64'(bus_cmd_out), 64'(WISHBONE_CMD_LOAD));
    @(negedge clk);
    check("mid_rst_in_wait", 64'(dbg_state_out), 64'(LSU_WAIT));
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    check("mid_rst_state",      64'(dbg_state_out),  64'(LSU_IDLE));
    check("mid_rst_ready_after",64'(req_ready_out),  64'd1);
    check("mid_rst_cmd",        64'(bus_cmd_out),    64'(WISHBONE_CMD_NONE));
    check("mid_rst_addr",       64'(bus_addr_out),   64'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      pulses += int'(resp_valid_out);
      @(negedge clk);
    end
    check("mid_rst_no_resp", 64'(pulses), 64'd0);

    // req_valid held through RESP is only taken once the FSM is back in IDLE.
    req_store_in = 1'b0; req_funct3_in = 3'b011; req_addr_in = 32'h100; req_valid_in = 1'b1;
    check("hold_ready", 64'(req_ready_out), 64'd1);
    exp_q.push_back({1'b1, 32'h0});
    @(negedge clk);
    check("hold_resp_state", 64'(dbg_state_out), 64'(LSU_RESP));
    check("hold_resp_ready", 64'(req_ready_out), 64'd0);
    @(negedge clk);
    check("hold_idle_state", 64'(dbg_state_out), 64'(LSU_IDLE));
    check("hold_idle_valid", 64'(resp_valid_out), 64'd0);
    req_funct3_in = 3'b010;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    @(negedge clk);
    req_valid_in = 1'b0;
    t_acc = cyc;
    check("hold_issue_cmd", 64'(bus_cmd_out), 64'(WISHBONE_CMD_LOAD));
    guard = 0;
    while (!resp_valid_out && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("hold_latency", 64'(cyc - t_acc), 64'd4);

    run_vec(mk("lw_after_rst", 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF,
               32'h100, 4'h0, 32'h0, 1));

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
